exhaustive_vector_sequencer: RTL and testbench
==============================================

# exhaustive_vector_sequencer

Sequencer that drives every input combination of an N_WIDTH-bit combinational/sequential benchmark DUT, waits a programmable settle time, captures the DUT output, and streams a (vector, response) record per combination to a downstream logger over a valid/ready handshake. It also folds all responses into a 16-bit MISR signature and a ones count for golden-vs-suspect (trojan) comparison. It sits between the benchmark DUT inputs/outputs and the result logger, replacing the fixed per-vector delay loop with a clocked, back-pressurable controller.

## Interface
- N_WIDTH, 4, DUT input width; 2^N_WIDTH vectors per run (1..16).
- OUT_WIDTH, 1, DUT output width (1..16).
- SETTLE_CYCLES, 1, cycles N is held before capture (>=1).

- CK  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  run request; sampled only in IDLE.
- N  output  N_WIDTH  stimulus vector to DUT.
- dut_out  input  OUT_WIDTH  DUT response.
- busy  output  1  high in SETTLE, CAPTURE, EMIT.
- done  output  1  one-cycle pulse (DONE state) at run end.
- rec_valid  output  1  record available.
- rec_ready  input  1  logger accepts record.
- rec_vector  output  N_WIDTH  vector of current record (equals N).
- rec_response  output  OUT_WIDTH  captured response.
- signature  output  16  MISR result; stable from DONE until next accepted start.
- ones_count  output  N_WIDTH+1  number of vectors with nonzero response.

## Operation
- States: IDLE, SETTLE, CAPTURE, EMIT, DONE.
- IDLE: start=1 -> SETTLE; vector register := 0, settle counter := SETTLE_CYCLES-1, signature := 0, ones_count := 0. start=0 -> stay.
- SETTLE: N = current vector. Counter at 0 -> CAPTURE, else decrement.
- CAPTURE (1 cycle): rec_response := dut_out; signature and ones_count update; -> EMIT.
- MISR update: s = {signature[14:0],1'b0}; if signature[15] then s ^= 16'h1021; signature := s ^ zero-extended dut_out.
- ones_count increments when dut_out != 0.
- EMIT: rec_valid=1, rec_vector/rec_response held stable until rec_valid&&rec_ready. On handshake: if vector == 2^N_WIDTH-1 -> DONE; else vector+1, counter reload, -> SETTLE.
- DONE: done=1 one cycle -> IDLE.
- start outside IDLE ignored (no queueing). start high in the DONE cycle ignored; start held high in IDLE restarts next cycle.
- N keeps the last driven vector in DONE/IDLE until next start (reset value 0).
- Vector register is N_WIDTH+1 bits internally or compared before increment; no wrap to 0 mid-run.

## Timing
- Reset values: N=0, busy=0, done=0, rec_valid=0, rec_vector=0, rec_response=0, signature=0, ones_count=0, state IDLE.
- Reset asserted mid-run: all outputs to reset values immediately (asynchronous); any in-flight record dropped; after release, block waits in IDLE for start.
- start sampled at edge 0 -> busy=1 and N=0 from edge 0.
- N changes only on the handshake edge leaving EMIT; DUT sees each vector for exactly SETTLE_CYCLES+1 cycles before capture edge.
- Per vector with rec_ready tied high: SETTLE_CYCLES+2 cycles. Full run: 2^N_WIDTH*(SETTLE_CYCLES+2) cycles then 1 DONE cycle.
- Each stalled EMIT cycle adds exactly one cycle; outputs unchanged during stall.
- rec_valid never deasserts without handshake (except reset).

## Test plan
- Defaults, rec_ready=1, dut_out=0, start pulse at edge 0 -> 16 records vectors 0..15 in order, done in cycle 48, signature=16'h0000, ones_count=0.
- dut_out=1 only when N==4'b1111 -> signature=16'h0001, ones_count=1; dut_out=1 only when N==0 -> signature=16'h8000, ones_count=1.
- rec_ready low 3 cycles at vector 5 EMIT -> rec_vector=5/rec_response stable for 4 cycles, N stays 5, run length 51 cycles, no record lost or duplicated.
- SETTLE_CYCLES=3 with a DUT of one-cycle registered output -> each captured response matches that vector; run length 16*5 cycles.
- reset asserted during vector 7 SETTLE -> all outputs 0 asynchronously; start after release -> fresh run from vector 0, signature restarts from 0.
- start pulsed while busy and in DONE -> ignored; record count stays 16, no second run.

Source files
------------

// File: rtl/exhaustive_vector_sequencer.sv
// Walks every N_WIDTH-bit input vector through a benchmark DUT, waits a settle time, captures the
// response, and streams (vector, response) records to a logger while folding responses into a MISR and a ones count.
module exhaustive_vector_sequencer #(
  parameter int unsigned N_WIDTH       = 4,
  parameter int unsigned OUT_WIDTH     = 1,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  output logic [N_WIDTH-1:0]   N,
  input  logic [OUT_WIDTH-1:0] dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [N_WIDTH-1:0]   rec_vector,
  output logic [OUT_WIDTH-1:0] rec_response,
  output logic [15:0]          signature,
  output logic [N_WIDTH:0]     ones_count
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [N_WIDTH-1:0] VEC_ONE    = N_WIDTH'(1);
  localparam logic [N_WIDTH:0]   ONES_ONE   = (N_WIDTH + 1)'(1);
  localparam logic [15:0]        MISR_POLY  = 16'h1021;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_EMIT,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [N_WIDTH-1:0]     vec_q, vec_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]   resp_q, resp_d;
  logic [15:0]            sig_q, sig_d;
  logic [N_WIDTH:0]       ones_q, ones_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   valid_q, valid_d;
  logic [15:0]            misr_c;

  // Next MISR value folding the live DUT response into the running signature
  always_comb begin
    misr_c = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? MISR_POLY : 16'h0000) ^ 16'(dut_out);
  end

  // Next-state and next-register logic; last vector detected before increment so there is no wrap
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    sig_d   = sig_q;
    ones_d  = ones_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          vec_d   = '0;
          cnt_d   = CNT_RELOAD;
          sig_d   = '0;
          ones_d  = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_CAPTURE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      S_CAPTURE: begin
        resp_d  = dut_out;
        sig_d   = misr_c;
        if (|dut_out) ones_d = ones_q + ONES_ONE;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (rec_ready) begin
          if (&vec_q) begin
            state_d = S_DONE;
          end else begin
            vec_d   = vec_q + VEC_ONE;
            cnt_d   = CNT_RELOAD;
            state_d = S_SETTLE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d == S_SETTLE) || (state_d == S_CAPTURE) || (state_d == S_EMIT);
    done_d  = (state_d == S_DONE);
    valid_d = (state_d == S_EMIT);
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      resp_q  <= '0;
      sig_q   <= '0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      sig_q   <= sig_d;
      ones_q  <= ones_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign N            = vec_q;
  assign rec_vector   = vec_q;
  assign rec_response = resp_q;
  assign signature    = sig_q;
  assign ones_count   = ones_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign rec_valid    = valid_q;

endmodule

// File: tb/tb_exhaustive_vector_sequencer.sv
// Scoreboard bench: expected records are queued at start and popped on each logger handshake.
module tb_exhaustive_vector_sequencer;

  typedef struct {
    logic [3:0] v;
    logic [3:0] r;
  } rec_t;

  logic        clk;
  logic        rst_n;
  int          cyc;
  int          n_checks;
  int          n_pass;

  // Instance A: defaults, combinational DUT model
  logic        start_a, ready_a, dut_out_a;
  logic [3:0]  n_a, rec_vector_a;
  logic        busy_a, done_a, rec_valid_a, rec_response_a;
  logic [15:0] signature_a;
  logic [4:0]  ones_count_a;
  int          mode_a;
  int          rec_cnt_a;
  rec_t        exp_a[$];

  // Instance B: SETTLE_CYCLES=3, 4-bit registered DUT model
  logic        start_b, ready_b;
  logic [3:0]  dut_out_b;
  logic [3:0]  n_b, rec_vector_b, rec_response_b;
  logic        busy_b, done_b, rec_valid_b;
  logic [15:0] signature_b;
  logic [4:0]  ones_count_b;
  int          rec_cnt_b;
  rec_t        exp_b[$];

  exhaustive_vector_sequencer #(.N_WIDTH(4), .OUT_WIDTH(1), .SETTLE_CYCLES(1)) u_dut_a (
    .CK(clk), .reset(rst_n), .start(start_a), .N(n_a), .dut_out(dut_out_a),
    .busy(busy_a), .done(done_a), .rec_valid(rec_valid_a), .rec_ready(ready_a),
    .rec_vector(rec_vector_a), .rec_response(rec_response_a),
    .signature(signature_a), .ones_count(ones_count_a)
  );

  exhaustive_vector_sequencer #(.N_WIDTH(4), .OUT_WIDTH(4), .SETTLE_CYCLES(3)) u_dut_b (
    .CK(clk), .reset(rst_n), .start(start_b), .N(n_b), .dut_out(dut_out_b),
    .busy(busy_b), .done(done_b), .rec_valid(rec_valid_b), .rec_ready(ready_b),
    .rec_vector(rec_vector_b), .rec_response(rec_response_b),
    .signature(signature_b), .ones_count(ones_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic resp_a(input int mode, input logic [3:0] v);
    case (mode)
      1:       return (v == 4'hF);
      2:       return (v == 4'h0);
      3:       return v[0] ^ v[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] d);
    logic [15:0] t;
    t = {s[14:0], 1'b0};
    if (s[15]) t = t ^ 16'h1021;
    return t ^ d;
  endfunction

  always_comb dut_out_a = resp_a(mode_a, n_a);
  always @(posedge clk) dut_out_b <= n_b ^ 4'h9;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Record monitors: a handshake is seen at the falling edge before the accepting rising edge
  always @(negedge clk) begin
    if (rst_n && rec_valid_a && ready_a) begin
      rec_t r;
      rec_cnt_a++;
      if (exp_a.size() > 0) begin
        r = exp_a.pop_front();
        check("a_rec_vector", 32'(rec_vector_a), 32'(r.v));
        check("a_rec_response", 32'(rec_response_a), 32'(r.r));
        check("a_n_eq_vector", 32'(n_a), 32'(r.v));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rec_valid_b && ready_b) begin
      rec_t r;
      rec_cnt_b++;
      if (exp_b.size() > 0) begin
        r = exp_b.pop_front();
        check("b_rec_vector", 32'(rec_vector_b), 32'(r.v));
        check("b_rec_response", 32'(rec_response_b), 32'(r.r));
      end
    end
  end

  task automatic wait_done_a(input int c0, output int len);
    len = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_a) begin
        len = cyc - c0;
        break;
      end
    end
  endtask

  task automatic run_a(input int mode, input bit stall, input bit poke,
                       input logic [15:0] exp_sig, input int exp_ones, input int exp_len);
    int c0;
    int len;
    mode_a    = mode;
    rec_cnt_a = 0;
    for (int v = 0; v < 16; v++) exp_a.push_back('{4'(v), {3'b000, resp_a(mode, 4'(v))}});
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    c0 = cyc;
    check("a_busy_after_start", 32'(busy_a), 32'd1);
    check("a_n_after_start", 32'(n_a), 32'd0);
    if (stall) begin
      repeat (17) @(posedge clk);
      #1 ready_a = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (k == 3) ready_a = 1'b1;
        @(negedge clk);
        check("a_stall_valid", 32'(rec_valid_a), 32'd1);
        check("a_stall_vector", 32'(rec_vector_a), 32'd5);
        check("a_stall_n", 32'(n_a), 32'd5);
        check("a_stall_resp", 32'(rec_response_a), 32'(resp_a(mode, 4'd5)));
        if (k < 3) begin
          @(posedge clk); #1;
        end
      end
    end
    if (poke) begin
      repeat (10) @(posedge clk);
      #1 start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
    end
    wait_done_a(c0, len);
    check("a_run_length", 32'(len), 32'(exp_len));
    check("a_signature", 32'(signature_a), 32'(exp_sig));
    check("a_ones_count", 32'(ones_count_a), 32'(exp_ones));
    check("a_record_count", 32'(rec_cnt_a), 32'd16);
    check("a_queue_drained", 32'(exp_a.size()), 32'd0);
    if (poke) start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    @(negedge clk);
    check("a_done_one_cycle", 32'(done_a), 32'd0);
    repeat (5) @(negedge clk);
    check("a_idle_after_done", 32'(busy_a), 32'd0);
    check("a_n_held", 32'(n_a), 32'd15);
    check("a_sig_stable", 32'(signature_a), 32'(exp_sig));
    check("a_no_extra_records", 32'(rec_cnt_a), 32'd16);
  endtask

  initial begin
    logic [15:0] sig3, sig_b;
    int          ones3;
    int          c0, len;
    rst_n = 1'b0; start_a = 1'b0; ready_a = 1'b1; start_b = 1'b0; ready_b = 1'b1;
    mode_a = 0; rec_cnt_a = 0; rec_cnt_b = 0; n_checks = 0; n_pass = 0;
    repeat (3) @(negedge clk);
    check("rst_n", 32'(n_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_valid", 32'(rec_valid_a), 32'd0);
    check("rst_sig_ones", 32'({signature_a, ones_count_a}), 32'd0);
    rst_n = 1'b1;

    run_a(0, 1'b0, 1'b1, 16'h0000, 0, 48);
    run_a(1, 1'b0, 1'b0, 16'h0001, 1, 48);
    run_a(2, 1'b0, 1'b0, 16'h8000, 1, 48);
    sig3 = '0; ones3 = 0;
    for (int v = 0; v < 16; v++) begin
      sig3 = misr_step(sig3, {15'd0, resp_a(3, 4'(v))});
      if (resp_a(3, 4'(v))) ones3++;
    end
    run_a(3, 1'b1, 1'b0, sig3, ones3, 51);

    // Reset during vector 7 settle, then a fresh run
    mode_a = 3; rec_cnt_a = 0;
    for (int v = 0; v < 16; v++) exp_a.push_back('{4'(v), {3'b000, resp_a(3, 4'(v))}});
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    check("pre_reset_n", 32'(n_a), 32'd7);
    check("pre_reset_records", 32'(rec_cnt_a), 32'd7);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_n", 32'(n_a), 32'd0);
    check("async_rst_busy_valid", 32'({busy_a, rec_valid_a, done_a}), 32'd0);
    check("async_rst_vec_resp", 32'({rec_vector_a, rec_response_a}), 32'd0);
    check("async_rst_sig_ones", 32'({signature_a, ones_count_a}), 32'd0);
    exp_a.delete();
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_idle", 32'(busy_a), 32'd0);
    run_a(1, 1'b0, 1'b0, 16'h0001, 1, 48);

    // Longer settle with a registered DUT
    rec_cnt_b = 0; sig_b = '0;
    for (int v = 0; v < 16; v++) begin
      exp_b.push_back('{4'(v), 4'(v) ^ 4'h9});
      sig_b = misr_step(sig_b, {12'd0, 4'(v) ^ 4'h9});
    end
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    c0 = cyc; len = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_b) begin
        len = cyc - c0;
        break;
      end
    end
    check("b_run_length", 32'(len), 32'd80);
    check("b_signature", 32'(signature_b), 32'(sig_b));
    check("b_ones_count", 32'(ones_count_b), 32'd15);
    check("b_record_count", 32'(rec_cnt_b), 32'd16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
